// File: rtl/rot_pkg.sv
// Shared op codes, FSM state encodings and the register reset/clear value
// for the rotating count sequencer.
package rot_pkg;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ROTL  = 2'b10;
    localparam logic [1:0] OP_ROTR  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One-hot bit 0; cast to the register width at the point of use.
    localparam int COUNT_INIT = 1;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/ring_shift_reg.sv
// WIDTH-bit rotating register; clear beats load, and both beat rotate.
module ring_shift_reg
    import rot_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= WIDTH'(COUNT_INIT);
        end else if (clear) begin
            q <= WIDTH'(COUNT_INIT);
        end else if (load) begin
            q <= d;
        end else if (en) begin
            if (dir == DIR_RIGHT) q <= {q[0], q[WIDTH-1:1]};
            else                  q <= {q[WIDTH-2:0], q[WIDTH-1]};
        end
    end

endmodule

// File: rtl/rot_seq_ctrl.sv
// Command sequencer driving ring_shift_reg: CLEAR / LOAD / ROTL n / ROTR n.
// Define ROT_SEQ_TRACE_EN to get simulation trace lines for updates and completions.
//
// state | meaning
// IDLE  | ready for a command
// EXEC  | applying the captured command (one cycle, or one per rotation step)
// DONE  | one-cycle completion pulse, no accept
module rot_seq_ctrl
    import rot_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [CNT_W-1:0] req_steps,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] steps_q;

    logic is_rot_req;
    logic sr_clear, sr_load, sr_en, sr_dir;

    assign is_rot_req = req_op[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= OP_CLEAR;
            data_q  <= '0;
            steps_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        data_q  <= req_data;
                        steps_q <= req_steps;
                        // A zero-step rotation has nothing to execute.
                        if (is_rot_req && req_steps == '0) state <= ST_DONE;
                        else                               state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_ROTL || op_q == OP_ROTR) begin
                        steps_q <= steps_q - CNT_W'(1);
                        if (steps_q == CNT_W'(1)) state <= ST_DONE;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sr_clear = 1'b0;
        sr_load  = 1'b0;
        sr_en    = 1'b0;
        sr_dir   = DIR_LEFT;
        if (state == ST_EXEC) begin
            sr_clear = (op_q == OP_CLEAR);
            sr_load  = (op_q == OP_LOAD);
            sr_en    = (op_q == OP_ROTL) || (op_q == OP_ROTR);
            sr_dir   = (op_q == OP_ROTR) ? DIR_RIGHT : DIR_LEFT;
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    ring_shift_reg #(.WIDTH(WIDTH)) u_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sr_load),
        .clear (sr_clear),
        .en    (sr_en),
        .dir   (sr_dir),
        .d     (data_q),
        .q     (count)
    );

`ifdef ROT_SEQ_TRACE_EN
    logic trace_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trace_upd <= 1'b0;
        else        trace_upd <= (state == ST_EXEC);
    end

    // Sampled on the falling edge so the register has already taken its new value.
    always @(negedge clk) begin
        if (rst_n && trace_upd)
            $display("rot_seq_ctrl: op=%0d remaining=%0d count=%b", op_q, steps_q, count);
        if (rst_n && done)
            $display("rot_seq_ctrl: op=%0d complete count=%b", op_q, count);
    end
`endif

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Self-checking bench for rot_seq_ctrl: per-cycle comparison against a
// timeline model built from the command rules, plus directed literal checks.
module tb_rot_seq_ctrl;

    localparam int W = 4;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [W-1:0] req_data = '0;
    logic [C-1:0] req_steps = '0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    rot_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_steps (req_steps),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         rdy;
        logic         bsy;
        logic         dn;
    } exp_t;

    exp_t         q[$];
    exp_t         cur;
    logic [W-1:0] m_count = 4'b0001;
    bit           acc;
    int           checks = 0;
    int           errors = 0;
    int           wait_ticks;

    function automatic exp_t mk(logic [W-1:0] c, logic r, logic b, logic d);
        exp_t e;
        e.cnt = c; e.rdy = r; e.bsy = b; e.dn = d;
        return e;
    endfunction

    // Rotation by k positions as plain arithmetic on an integer.
    function automatic logic [W-1:0] rot(logic [W-1:0] v, int k, bit left);
        int s;
        int x;
        s = k % W;
        if (!left) s = (W - s) % W;
        x = int'(v);
        x = ((x << s) | (x >> (W - s))) & ((1 << W) - 1);
        return x[W-1:0];
    endfunction

    // Expected outputs for every cycle from the accept edge until back in idle.
    task automatic build_timeline(logic [1:0] op, logic [W-1:0] data, int steps);
        logic [W-1:0] nv;
        if (op[1] == 1'b0) begin
            nv = (op == 2'b00) ? 4'b0001 : data;
            q.push_back(mk(m_count, 0, 1, 0));
            q.push_back(mk(nv, 0, 1, 1));
        end else if (steps == 0) begin
            nv = m_count;
            q.push_back(mk(m_count, 0, 1, 1));
        end else begin
            q.push_back(mk(m_count, 0, 1, 0));
            for (int k = 1; k < steps; k++)
                q.push_back(mk(rot(m_count, k, op == 2'b10), 0, 1, 0));
            nv = rot(m_count, steps, op == 2'b10);
            q.push_back(mk(nv, 0, 1, 1));
        end
        q.push_back(mk(nv, 1, 0, 0));
        m_count = nv;
    endtask

    task automatic check_exp(string name, exp_t e);
        checks++;
        if ({count, req_ready, busy, done} !== e) begin
            errors++;
            $display("FAIL %s t=%0t got count=%b ready=%b busy=%b done=%b want count=%b ready=%b busy=%b done=%b",
                     name, $time, count, req_ready, busy, done, e.cnt, e.rdy, e.bsy, e.dn);
        end
    endtask

    task automatic pin(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        acc = 0;
        if (!rst_n) begin
            q.delete();
            m_count = 4'b0001;
            cur = mk(4'b0001, 1, 0, 0);
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (req_valid) begin
            build_timeline(req_op, req_data, int'(req_steps));
            cur = q.pop_front();
            acc = 1;
        end else begin
            cur = mk(m_count, 1, 0, 0);
        end
        #1;
        check_exp("cycle", cur);
    endtask

    task automatic send(logic [1:0] op, logic [W-1:0] data, logic [C-1:0] steps);
        req_op = op; req_data = data; req_steps = steps; req_valid = 1'b1;
        wait_ticks = 0;
        do begin
            tick();
            wait_ticks++;
        end while (!acc && wait_ticks < 40);
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout t=%0t op=%0d", $time, op);
        end
        req_valid = 1'b0;
        req_op = 2'($urandom); req_data = W'($urandom); req_steps = C'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() > 0 || !cur.rdy) && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        m_count = 4'b0001;
        cur = mk(4'b0001, 1, 0, 0);
        check_exp("async_reset", cur);
        pin("reset_count", int'(count), 1);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        #1;
        pin("por_count", int'(count), 4'b0001);
        pin("por_ready", int'(req_ready), 1);
        pin("por_busy", int'(busy), 0);
        pin("por_done", int'(done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // LOAD 1010
        send(2'b01, 4'b1010, 4'd0);
        tick(); pin("load_count", int'(count), 4'b1010); pin("load_done", int'(done), 1);
        tick(); pin("load_ready", int'(req_ready), 1); pin("load_done_end", int'(done), 0);

        // ROTL 3 from 0001
        send(2'b00, 4'b0000, 4'd0); wait_idle();
        send(2'b10, 4'b0000, 4'd3);
        tick(); pin("rotl_1", int'(count), 4'b0010);
        tick(); pin("rotl_2", int'(count), 4'b0100);
        tick(); pin("rotl_3", int'(count), 4'b1000); pin("rotl_done", int'(done), 1);
        tick(); pin("rotl_ready", int'(req_ready), 1);

        // ROTR 5 from 0001, wrapping
        send(2'b00, 4'b0000, 4'd0); wait_idle();
        send(2'b11, 4'b0000, 4'd5);
        tick(); pin("rotr_1", int'(count), 4'b1000);
        tick(); pin("rotr_2", int'(count), 4'b0100);
        tick(); pin("rotr_3", int'(count), 4'b0010);
        tick(); pin("rotr_4", int'(count), 4'b0001);
        tick(); pin("rotr_5", int'(count), 4'b1000); pin("rotr_done", int'(done), 1);
        tick();

        // ROTR 0: straight to completion, count unchanged
        send(2'b11, 4'b0000, 4'd0);
        pin("rot0_done", int'(done), 1); pin("rot0_count", int'(count), 4'b1000);
        tick(); pin("rot0_ready", int'(req_ready), 1);

        // Held request during ROTL 4 must wait for idle
        send(2'b10, 4'b0000, 4'd4);
        send(2'b01, 4'b0110, 4'd0);
        pin("held_wait_ticks", wait_ticks, 6);
        wait_idle();
        pin("held_count", int'(count), 4'b0110);

        // Reset during step 2 of ROTL 6
        send(2'b00, 4'b0000, 4'd0); wait_idle();
        send(2'b10, 4'b0000, 4'd6);
        tick();
        async_reset();
        tick(); pin("post_reset_done", int'(done), 0);
        send(2'b10, 4'b0000, 4'd1);
        tick(); pin("post_reset_rot", int'(count), 4'b0010);
        wait_idle();

        // Randomized commands against the timeline model
        for (int i = 0; i < 300; i++) begin
            logic [1:0]   op;
            logic [C-1:0] st;
            op = 2'($urandom);
            st = ($urandom_range(0, 3) == 0) ? C'($urandom_range(0, 1)) : C'($urandom);
            send(op, W'($urandom), st);
            if ($urandom_range(0, 24) == 0) begin
                repeat ($urandom_range(0, 2)) tick();
                async_reset();
            end else if ($urandom_range(0, 2) == 0) begin
                // next command arrives while still busy
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
